// File: rtl/movegen_sequencer.sv
// movegen_sequencer: runs one move-generation job. Latches the host command,
// replays 64 square nibbles onto the board's serial load bus, pulses
// gen_start, buffers the board's move stream in a first-word-fall-through
// FIFO and drains it to the host under valid/ready.
// Optional COLLECT watchdog: define MOVEGEN_SEQ_TIMEOUT_EN.
module movegen_sequencer #(
  parameter int FIFO_DEPTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_wtp,
  input  logic [3:0]  i_cmd_castle,
  input  logic [2:0]  i_cmd_ep,
  input  logic        i_sq_valid,
  input  logic [3:0]  i_sq_data,
  output logic        o_sq_ready,
  output logic        o_pos_valid,
  output logic [3:0]  o_pos_data,
  output logic        o_pos_sop,
  output logic        o_pos_eop,
  output logic        o_pos_wtp,
  output logic [3:0]  o_pos_castle,
  output logic [2:0]  o_pos_ep,
  output logic        o_gen_start,
  input  logic        i_mv_valid,
  input  logic [19:0] i_mv_data,
  input  logic        i_mv_eop,
  output logic        o_out_valid,
  output logic [19:0] o_out_data,
  output logic        o_out_last,
  input  logic        i_out_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_move_count,
  output logic        o_overflow,
  output logic        o_timeout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_COLLECT,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [5:0]    r_sq_cnt;
  logic          r_pos_valid;
  logic [3:0]    r_pos_data;
  logic          r_pos_sop;
  logic          r_pos_eop;
  logic          r_pos_wtp;
  logic [3:0]    r_pos_castle;
  logic [2:0]    r_pos_ep;
  logic          r_gen_start;
  logic [7:0]    r_move_count;
  logic          r_overflow;

  logic [20:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_cmd_acc;
  logic          w_sq_acc;
  logic          w_mv_beat;
  logic          w_term;
  logic          w_counted;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  logic          w_out_valid;
  logic          w_pop;
  logic          w_timeout_hit;
  logic          w_timeout_fire;
  logic [20:0]   w_head;

  assign w_cmd_acc   = (r_state == S_IDLE) && i_cmd_valid;
  assign w_sq_acc    = (r_state == S_LOAD) && i_sq_valid;
  assign w_mv_beat   = (r_state == S_COLLECT) && i_mv_valid;
  // An eop beat carrying an all-zero move only terminates an empty list.
  assign w_term      = i_mv_eop && (i_mv_data == 20'd0);
  assign w_counted   = w_mv_beat && !w_term;
  // Fullness is judged on the registered count, before any same-cycle pop.
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_push      = w_counted && !w_full;
  assign w_drop      = w_counted && w_full;
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid && i_out_ready &&
                       ((r_state == S_COLLECT) || (r_state == S_DRAIN));
  assign w_timeout_fire = (r_state == S_COLLECT) && w_timeout_hit && !i_mv_valid;
  assign w_head      = r_mem[r_rd_ptr];

`ifdef MOVEGEN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_timeout;

  assign w_timeout_hit = (r_to_cnt == TW'(TIMEOUT_CYCLES));
  assign o_timeout     = r_timeout;

  // Silence counter: counts COLLECT cycles since the last move beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state != S_COLLECT) || i_mv_valid) begin
      r_to_cnt <= '0;
    end else if (!w_timeout_hit) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Sticky timeout flag, cleared when a new job is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_cmd_acc) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_fire) begin
      r_timeout <= 1'b1;
    end
  end
`else
  // Watchdog compiled out: the comparison is constant false.
  assign w_timeout_hit = (TIMEOUT_CYCLES < 0);
  assign o_timeout     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the job sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_cmd_acc) w_state_next = S_LOAD;
      S_LOAD:    if (w_sq_acc && (r_sq_cnt == 6'd63)) w_state_next = S_START;
      S_START:   w_state_next = S_COLLECT;
      S_COLLECT: begin
        if (w_mv_beat && i_mv_eop) begin
          w_state_next = S_DRAIN;
        end else if (w_timeout_fire) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN:   if (r_count == '0) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Command latch, square replay, start pulse and job statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq_cnt     <= '0;
      r_pos_valid  <= 1'b0;
      r_pos_data   <= '0;
      r_pos_sop    <= 1'b0;
      r_pos_eop    <= 1'b0;
      r_pos_wtp    <= 1'b0;
      r_pos_castle <= '0;
      r_pos_ep     <= '0;
      r_gen_start  <= 1'b0;
      r_move_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_pos_valid <= w_sq_acc;
      r_pos_data  <= w_sq_acc ? i_sq_data : 4'd0;
      r_pos_sop   <= w_sq_acc && (r_sq_cnt == 6'd0);
      r_pos_eop   <= w_sq_acc && (r_sq_cnt == 6'd63);
      r_gen_start <= (r_state == S_START);
      if (w_cmd_acc) begin
        r_pos_wtp    <= i_cmd_wtp;
        r_pos_castle <= i_cmd_castle;
        r_pos_ep     <= i_cmd_ep;
        r_sq_cnt     <= '0;
        r_move_count <= '0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_sq_acc) r_sq_cnt <= r_sq_cnt + 1'b1;
        if (w_counted && (r_move_count != 8'hFF)) r_move_count <= r_move_count + 1'b1;
        if (w_drop) r_overflow <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage; entries carry {eop, move}.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_mv_eop, i_mv_data};
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_sq_ready   = (r_state == S_LOAD);
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DRAIN) && (r_count == '0);
  assign o_pos_valid  = r_pos_valid;
  assign o_pos_data   = r_pos_data;
  assign o_pos_sop    = r_pos_sop;
  assign o_pos_eop    = r_pos_eop;
  assign o_pos_wtp    = r_pos_wtp;
  assign o_pos_castle = r_pos_castle;
  assign o_pos_ep     = r_pos_ep;
  assign o_gen_start  = r_gen_start;
  assign o_out_valid  = w_out_valid;
  assign o_out_data   = w_out_valid ? w_head[19:0] : 20'd0;
  assign o_out_last   = w_out_valid && w_head[20];
  assign o_move_count = r_move_count;
  assign o_overflow   = r_overflow;

endmodule
